pe_vec: RTL and testbench
=========================

# pe_vec

Parametrised successor to the systolic-array processing element. It buffers the row operand (A) and column operand (B) streams in independent FIFOs, forwards each consumed operand to its east/south neighbour, and performs a signed multiply-accumulate over a programmable number of pairs. It presents a width-clipped result with a saturation flag. Data width and FIFO depth are generic, and neighbour back-pressure is handled so instances tile directly into an N×M array.

## Interface
- DW, 16: operand and result width, signed.
- FDEPTH, 4: per-operand FIFO depth, power of two, at least 2.
- SHIFT, 0: result right-shift amount. Used only with PE_ROUND_EN.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle pulse that begins a dot product.
- max_cntr  in  8  number of operand pairs; sampled on accepted start.
- a_in / b_in  in  DW  operand write data.
- awe / bwe  in  1  operand write enables.
- aff / bff  out  1  FIFO full.
- a_ns / b_ns  in  1  neighbour stall: downstream FIFO full (neighbour aff/bff).
- a_out / b_out  out  DW  forwarded operand.
- aoe / boe  out  1  forwarded operand valid (drives neighbour awe/bwe).
- start_next  out  1  start delayed one cycle, for the neighbour.
- se  out  1  one-cycle s_out valid strobe.
- s_out  out  DW  clipped result.
- sat  out  1  result was clipped.
- fout  out  1  busy: high in RUN and OUT.

## Operation
- Reset values: all outputs 0, FIFOs empty, accumulator 0, state IDLE.
- FIFOs accept writes in every state.
  - A write to a full FIFO is dropped, unless a pop occurs in the same cycle; then the write is accepted.
  - aff/bff reflect the registered occupancy of FDEPTH.
- States:
  - IDLE, on start: load count ← max_cntr, clear acc and sat.
    - If max_cntr == 0, go to OUT.
    - Otherwise go to RUN.
  - RUN, pop condition: both FIFOs non-empty, a_ns == 0, b_ns == 0.
    - On a pop: acc ← acc + a·b, and count decrements.
    - When count reaches 0 on a pop, go to OUT.
  - OUT: se = 1 for one cycle, then go to IDLE.
- start is ignored outside IDLE. start_next is start registered, regardless of state.
- Arithmetic:
  - The product is 2·DW bits; the accumulator is 2·DW+8 bits, so 255 pairs never overflow.
  - s_out = acc clipped to [−2^(DW−1), 2^(DW−1)−1].
  - sat = 1 if the value was clipped.
  - s_out and sat hold until the next accepted start.
- Reset mid-operation: an asynchronous return to reset values. FIFO contents are discarded and no se is issued.

## Timing
- Pop in cycle T:
  - acc is updated at the edge ending T.
  - a_out/b_out are registered with the popped values at the same edge.
  - aoe/boe are high in T+1 for one cycle.
- At most one pop per cycle, giving a throughput of 1 pair/cycle with no stalls.
- Last pop in T: se and the valid s_out/sat appear in T+1, and IDLE is reached in T+2.
- start accepted in T: the first pop can occur in T+1.
- start with max_cntr == 0: se is high in T+1 with s_out = 0, sat = 0.
- Write in T: the data is poppable from T+1, and aff can assert at the edge ending T.
- a_ns/b_ns are sampled combinationally in the pop cycle.

## Configuration
- PE_ROUND_EN defined:
  - Before clipping, the result is computed as (acc + 2^(SHIFT−1)) >>> SHIFT, arithmetic and round-half-up.
  - When SHIFT == 0, no rounding term is added.
  - sat reflects the clip of the shifted value.
- PE_ROUND_EN undefined: SHIFT is ignored, and acc is clipped directly.

## Test plan
- Basic MAC:
  - Stimulus: reset; max_cntr=4; start; then write A = −1, −2, 2, −2 and B = −2, 3, −5, −5 on consecutive cycles.
  - Response: four aoe/boe pulses forwarding the same values; se once; s_out = −4; sat = 0; fout falls after se.
- Saturation:
  - Stimulus: DW=16, max_cntr=2, A = 32767, 32767, B = 32767, 32767.
  - Response: s_out = 32767, sat = 1.
  - Stimulus: A = −32768, B = 32767, max_cntr=1.
  - Response: s_out = −32768, sat = 1.
- Back-pressure and full:
  - Stimulus: a_ns=1 and five A/B writes before start.
  - Response: aff/bff high after the 4th write; the 5th write is dropped; no pops while a_ns=1.
  - Stimulus: start with max_cntr=4, then release a_ns.
  - Response: exactly 4 pops; the dropped 5th pair never appears on a_out.
- Simultaneous write and pop on a full FIFO:
  - Response: the write is accepted; occupancy stays at FDEPTH; the value is popped in order later.
- Zero count and ignored start:
  - Stimulus: max_cntr=0.
  - Response: se in the next cycle, s_out = 0.
  - Stimulus: start pulsed during RUN.
  - Response: no effect on count or result; start_next still pulses one cycle later.
- Reset mid-RUN:
  - Stimulus: drop rst_n after 2 of 4 pops.
  - Response: all outputs return to 0 immediately; FIFOs are empty; no se.
  - Stimulus: a fresh run with max_cntr=1, A=3, B=4.
  - Response: s_out = 12.
  - With PE_ROUND_EN and SHIFT=2, the same run gives s_out = 3.

Source files
------------

// File: rtl/pe_vec.sv
// rtl/pe_vec.sv - systolic MAC processing element with operand FIFOs and neighbour forwarding (option: PE_ROUND_EN)

// Operand FIFO: registered occupancy; a write to a full FIFO lands only if a pop frees a slot that cycle
module pe_vec_fifo #(
  parameter int DW     = 16,
  parameter int FDEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] wdata,
  input  logic          we,
  input  logic          pop,
  output logic [DW-1:0] rdata,
  output logic          empty,
  output logic          full
);
  localparam int AW = $clog2(FDEPTH);

  logic [DW-1:0] mem [FDEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   cnt;
  logic          wr_ok;

  assign empty = (cnt == '0);
  assign full  = (cnt == (AW+1)'(FDEPTH));
  assign wr_ok = we && (!full || pop);
  assign rdata = mem[rptr];

  // Storage array, written on every accepted write
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wptr] <= wdata;
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (wr_ok) wptr <= wptr + 1'b1;
      if (pop)   rptr <= rptr + 1'b1;
      case ({wr_ok, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

module pe_vec #(
  parameter int DW     = 16,
  parameter int FDEPTH = 4,
  parameter int SHIFT  = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [7:0]    max_cntr,
  input  logic [DW-1:0] a_in,
  input  logic [DW-1:0] b_in,
  input  logic          awe,
  input  logic          bwe,
  output logic          aff,
  output logic          bff,
  input  logic          a_ns,
  input  logic          b_ns,
  output logic [DW-1:0] a_out,
  output logic [DW-1:0] b_out,
  output logic          aoe,
  output logic          boe,
  output logic          start_next,
  output logic          se,
  output logic [DW-1:0] s_out,
  output logic          sat,
  output logic          fout
);
  // Accumulator has 8 guard bits so 255 full-scale products cannot wrap
  localparam int ACCW = 2*DW + 8;

`ifdef PE_ROUND_EN
  localparam bit ROUND_EN = 1'b1;
`else
  localparam bit ROUND_EN = 1'b0;
`endif

  // Without rounding the shift collapses to zero, making the scale path an identity
  localparam int EFF_SHIFT = ROUND_EN ? SHIFT : 0;
  localparam logic signed [ACCW-1:0] RND   = ACCW'((1 << EFF_SHIFT) >> 1);
  localparam logic signed [ACCW-1:0] S_MAX = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACCW-1:0] S_MIN = {{(ACCW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, OUT} state_t;

  state_t                  state;
  logic [7:0]              remain;
  logic signed [ACCW-1:0]  acc;
  logic signed [ACCW-1:0]  acc_next;
  logic signed [ACCW-1:0]  scaled;
  logic signed [2*DW-1:0]  prod;
  logic [DW-1:0]           a_data;
  logic [DW-1:0]           b_data;
  logic                    a_empty;
  logic                    b_empty;
  logic                    pop;
  logic [DW-1:0]           res;
  logic                    res_sat;

  pe_vec_fifo #(.DW(DW), .FDEPTH(FDEPTH)) u_afifo (
    .clk(clk), .rst_n(rst_n), .wdata(a_in), .we(awe), .pop(pop),
    .rdata(a_data), .empty(a_empty), .full(aff)
  );

  pe_vec_fifo #(.DW(DW), .FDEPTH(FDEPTH)) u_bfifo (
    .clk(clk), .rst_n(rst_n), .wdata(b_in), .we(bwe), .pop(pop),
    .rdata(b_data), .empty(b_empty), .full(bff)
  );

  // A pair is consumed only when both operands exist and neither neighbour is stalled
  assign pop = (state == RUN) && !a_empty && !b_empty && !a_ns && !b_ns;

  assign prod     = (2*DW)'($signed(a_data)) * (2*DW)'($signed(b_data));
  assign acc_next = acc + ACCW'(prod);
  assign scaled   = (acc_next + RND) >>> EFF_SHIFT;

  // Clip the (optionally rounded) running sum to the signed output range
  always_comb begin
    res     = scaled[DW-1:0];
    res_sat = 1'b0;
    if (scaled > S_MAX) begin
      res     = S_MAX[DW-1:0];
      res_sat = 1'b1;
    end else if (scaled < S_MIN) begin
      res     = S_MIN[DW-1:0];
      res_sat = 1'b1;
    end
  end

  // Control FSM with accumulator and registered result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      remain <= '0;
      acc    <= '0;
      s_out  <= '0;
      sat    <= 1'b0;
      se     <= 1'b0;
      fout   <= 1'b0;
    end else begin
      se <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            remain <= max_cntr;
            acc    <= '0;
            s_out  <= '0;
            sat    <= 1'b0;
            fout   <= 1'b1;
            if (max_cntr == 8'd0) begin
              state <= OUT;
              se    <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (pop) begin
            acc    <= acc_next;
            remain <= remain - 8'd1;
            if (remain == 8'd1) begin
              state <= OUT;
              se    <= 1'b1;
              s_out <= res;
              sat   <= res_sat;
            end
          end
        end
        OUT: begin
          state <= IDLE;
          fout  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Forward each popped pair to the east/south neighbours, and pass start along
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_out      <= '0;
      b_out      <= '0;
      aoe        <= 1'b0;
      boe        <= 1'b0;
      start_next <= 1'b0;
    end else begin
      aoe        <= pop;
      boe        <= pop;
      start_next <= start;
      if (pop) begin
        a_out <= a_data;
        b_out <= b_data;
      end
    end
  end
endmodule

// File: tb/tb_pe_vec.sv
// tb/tb_pe_vec.sv - directed table-driven bench for pe_vec
module tb_pe_vec;
  localparam int DW     = 16;
  localparam int FDEPTH = 4;
  localparam int SHIFT  = 2;
`ifdef PE_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [7:0]    max_cntr;
  logic [DW-1:0] a_in;
  logic [DW-1:0] b_in;
  logic          awe;
  logic          bwe;
  logic          aff;
  logic          bff;
  logic          a_ns;
  logic          b_ns;
  logic [DW-1:0] a_out;
  logic [DW-1:0] b_out;
  logic          aoe;
  logic          boe;
  logic          start_next;
  logic          se;
  logic [DW-1:0] s_out;
  logic          sat;
  logic          fout;

  pe_vec #(.DW(DW), .FDEPTH(FDEPTH), .SHIFT(SHIFT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .max_cntr(max_cntr),
    .a_in(a_in), .b_in(b_in), .awe(awe), .bwe(bwe), .aff(aff), .bff(bff),
    .a_ns(a_ns), .b_ns(b_ns), .a_out(a_out), .b_out(b_out), .aoe(aoe), .boe(boe),
    .start_next(start_next), .se(se), .s_out(s_out), .sat(sat), .fout(fout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int aq[$];
  int bq[$];
  int se_cnt = 0;

  always @(negedge clk) begin
    if (aoe) aq.push_back(int'($signed(a_out)));
    if (boe) bq.push_back(int'($signed(b_out)));
    if (se) se_cnt++;
  end

  typedef struct packed {
    logic [7:0]             n;
    logic [3:0][DW-1:0]     a;
    logic [3:0][DW-1:0]     b;
    logic signed [DW-1:0]   exp_s;
    logic                   exp_sat;
    logic signed [DW-1:0]   rnd_s;
    logic                   rnd_sat;
  } vec_t;

  vec_t vt[11];

  function automatic vec_t mk(int n, int a0, int a1, int a2, int a3, int b0, int b1, int b2, int b3,
                              int es, int esat, int rs, int rsat);
    vec_t v;
    v.n = 8'(n);
    v.a[0] = DW'(a0); v.a[1] = DW'(a1); v.a[2] = DW'(a2); v.a[3] = DW'(a3);
    v.b[0] = DW'(b0); v.b[1] = DW'(b1); v.b[2] = DW'(b2); v.b[3] = DW'(b3);
    v.exp_s = DW'(es); v.exp_sat = esat[0]; v.rnd_s = DW'(rs); v.rnd_sat = rsat[0];
    return v;
  endfunction

  function automatic int ev(int d, int r);
    return RND ? r : d;
  endfunction

  task automatic check(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(int a, int b);
    awe = 1'b1; bwe = 1'b1; a_in = DW'(a); b_in = DW'(b);
    tick();
    awe = 1'b0; bwe = 1'b0;
  endtask

  task automatic go(int n);
    max_cntr = 8'(n); start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_se(string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (se) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    check(name, int'(seen), 1);
  endtask

  initial begin
    int se_before;
    rst_n = 1'b1; start = 1'b0; max_cntr = '0; a_in = '0; b_in = '0;
    awe = 1'b0; bwe = 1'b0; a_ns = 1'b0; b_ns = 1'b0;

    vt[0]  = mk(4, -1, -2, 2, -2, -2, 3, -5, -5, -4, 0, -1, 0);
    vt[1]  = mk(2, 32767, 32767, 0, 0, 32767, 32767, 0, 0, 32767, 1, 32767, 1);
    vt[2]  = mk(1, -32768, 0, 0, 0, 32767, 0, 0, 0, -32768, 1, -32768, 1);
    vt[3]  = mk(3, 100, -200, 7, 0, 3, 4, -5, 0, -535, 0, -134, 0);
    vt[4]  = mk(2, 1, 1, 0, 0, 2, 4, 0, 0, 6, 0, 2, 0);
    vt[5]  = mk(1, 250, 0, 0, 0, 400, 0, 0, 0, 32767, 1, 25000, 0);
    vt[6]  = mk(1, 32767, 0, 0, 0, 1, 0, 0, 0, 32767, 0, 8192, 0);
    vt[7]  = mk(1, -32768, 0, 0, 0, 1, 0, 0, 0, -32768, 0, -8192, 0);
    vt[8]  = mk(1, 16384, 0, 0, 0, 2, 0, 0, 0, 32767, 1, 8192, 0);
    vt[9]  = mk(4, -32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768, 32767, 1, 32767, 1);
    vt[10] = mk(4, -32768, -32768, -32768, -32768, 32767, 32767, 32767, 32767, -32768, 1, -32768, 1);

    #3 rst_n = 1'b0;
    tick(); tick();
    check("rst_s_out", int'(s_out), 0);
    check("rst_flags", int'({se, sat, fout, aoe, boe, aff, bff, start_next}), 0);
    check("rst_a_out", int'(a_out), 0);
    rst_n = 1'b1;
    tick();

    // Table: load the pairs, start, collect the result and forwarded operands
    for (int k = 0; k < 11; k++) begin
      for (int i = 0; i < int'(vt[k].n); i++) put(int'($signed(vt[k].a[i])), int'($signed(vt[k].b[i])));
      aq.delete(); bq.delete();
      se_before = se_cnt;
      go(int'(vt[k].n));
      wait_se($sformatf("v%0d_se", k));
      check($sformatf("v%0d_s_out", k), int'($signed(s_out)),
            ev(int'(vt[k].exp_s), int'(vt[k].rnd_s)));
      check($sformatf("v%0d_sat", k), int'(sat), ev(int'(vt[k].exp_sat), int'(vt[k].rnd_sat)));
      tick();
      check($sformatf("v%0d_fout_low", k), int'(fout), 0);
      check($sformatf("v%0d_se_once", k), se_cnt - se_before, 1);
      check($sformatf("v%0d_fwd_n", k), aq.size() + bq.size(), 2 * int'(vt[k].n));
      for (int i = 0; i < int'(vt[k].n) && i < aq.size() && i < bq.size(); i++) begin
        check($sformatf("v%0d_fwd_a%0d", k, i), aq[i], int'($signed(vt[k].a[i])));
        check($sformatf("v%0d_fwd_b%0d", k, i), bq[i], int'($signed(vt[k].b[i])));
      end
    end

    // Basic MAC with operands arriving after start
    aq.delete();
    go(4);
    put(-1, -2); put(-2, 3); put(2, -5); put(-2, -5);
    wait_se("late_se");
    check("late_s_out", int'($signed(s_out)), ev(-4, -1));
    tick();
    check("late_fwd_n", aq.size(), 4);

    // Back-pressure: fill past full while stalled, then release
    a_ns = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      put(i, 1);
      if (i == 4) check("bp_full", int'({aff, bff}), 3);
    end
    aq.delete();
    go(4);
    repeat (3) tick();
    check("bp_no_pop", aq.size(), 0);
    check("bp_busy", int'(fout), 1);
    a_ns = 1'b0;
    wait_se("bp_se");
    check("bp_s_out", int'($signed(s_out)), ev(10, 3));
    tick();
    check("bp_fwd_n", aq.size(), 4);
    if (aq.size() == 4) check("bp_last", aq[3], 4);
    check("bp_drained", int'({aff, bff}), 0);

    // Write and pop in the same cycle on a full FIFO
    put(10, 1); put(20, 1); put(30, 1); put(40, 1);
    aq.delete();
    max_cntr = 8'd5; start = 1'b1;
    tick();
    start = 1'b0; awe = 1'b1; bwe = 1'b1; a_in = DW'(50); b_in = DW'(1);
    tick();
    awe = 1'b0; bwe = 1'b0;
    check("wp_still_full", int'(aff), 1);
    wait_se("wp_se");
    check("wp_s_out", int'($signed(s_out)), ev(150, 38));
    tick();
    check("wp_fwd_n", aq.size(), 5);
    if (aq.size() == 5) check("wp_order", aq[4], 50);

    // Zero count
    go(0);
    check("z_se", int'(se), 1);
    check("z_s_out", int'($signed(s_out)), 0);
    check("z_sat", int'(sat), 0);
    tick();
    check("z_se_one", int'(se), 0);
    tick();
    check("z_idle", int'(fout), 0);

    // Start during RUN is ignored but still forwarded
    a_ns = 1'b1;
    put(2, 5); put(3, 7);
    aq.delete();
    go(2);
    max_cntr = 8'd1; start = 1'b1;
    tick();
    start = 1'b0;
    check("ign_start_next", int'(start_next), 1);
    check("ign_busy", int'(fout), 1);
    tick();
    check("ign_start_next_off", int'(start_next), 0);
    a_ns = 1'b0;
    wait_se("ign_se");
    check("ign_s_out", int'($signed(s_out)), ev(31, 8));
    tick();
    check("ign_fwd_n", aq.size(), 2);

    // Reset after two of four pops, with leftover data queued
    put(7, 1); put(8, 1);
    aq.delete();
    go(4);
    repeat (4) tick();
    check("mr_two_pops", aq.size(), 2);
    a_ns = 1'b1;
    put(9, 1); put(6, 1);
    se_before = se_cnt;
    #2 rst_n = 1'b0;
    #1;
    check("mr_s_out", int'(s_out), 0);
    check("mr_a_out", int'(a_out), 0);
    check("mr_flags", int'({se, sat, fout, aoe, boe, aff, bff, start_next}), 0);
    tick(); tick();
    rst_n = 1'b1;
    a_ns = 1'b0;
    tick();
    check("mr_no_se", se_cnt - se_before, 0);
    put(3, 4);
    aq.delete();
    go(1);
    wait_se("mr_fresh_se");
    check("mr_fresh_s_out", int'($signed(s_out)), ev(12, 3));
    tick();
    check("mr_fresh_n", aq.size(), 1);
    if (aq.size() == 1) check("mr_fifo_flushed", aq[0], 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
